// File: rtl/y_mem_update_writer.sv
`default_nettype none
// ============================================================================
//  Module   : y_mem_update_writer
//  Purpose  : Write-side engine for the Y-matrix memory. Accepts change
//             entries (row, column, complex delta) and performs a
//             read-modify-write of the 256-bit memory word that holds the
//             addressed element. The new value is either accumulated with
//             signed saturation or overwritten.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock, reset            rising-edge clock, synchronous active-low reset
//    chg_valid / chg_ready   change-entry handshake
//    chg_row, chg_col        matrix coordinates of the element
//    chg_real, chg_img       signed 24-bit delta (or new value)
//    chg_mode                0 = accumulate, 1 = overwrite
//    mem_rd_en/addr/data     memory read port, data one cycle after strobe
//    yMem_WEPin/WEAddress,
//    ydataWrite              memory write port
//    upd_done                one-cycle pulse with each issued write
//    err_range               one-cycle pulse for an out-of-range entry
//    sat_flag                sticky saturation indicator
//    upd_count               count of issued writes (wraps)
// ============================================================================
module y_mem_update_writer #(
  parameter int MAX_ROW      = 64,
  parameter int COLS_PER_ROW = 20
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         chg_valid,
  output logic         chg_ready,
  input  logic [15:0]  chg_row,
  input  logic [15:0]  chg_col,
  input  logic [23:0]  chg_real,
  input  logic [23:0]  chg_img,
  input  logic         chg_mode,
  output logic         mem_rd_en,
  output logic [7:0]   mem_rd_addr,
  input  logic [255:0] mem_rd_data,
  output logic         yMem_WEPin,
  output logic [7:0]   yMem_WEAddress,
  output logic [255:0] ydataWrite,
  output logic         upd_done,
  output logic         err_range,
  output logic         sat_flag,
  output logic [15:0]  upd_count
);

  localparam logic [16:0] ROW_LIMIT = 17'(MAX_ROW);
  localparam logic [16:0] COL_LIMIT = 17'(COLS_PER_ROW);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_READ  = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Column -> {word[1:0], slot[2:0]}; five 48-bit slots per memory word.
  function automatic logic [4:0] col_lut(input logic [4:0] c);
    case (c)
      5'd0:    col_lut = {2'd0, 3'd0};
      5'd1:    col_lut = {2'd0, 3'd1};
      5'd2:    col_lut = {2'd0, 3'd2};
      5'd3:    col_lut = {2'd0, 3'd3};
      5'd4:    col_lut = {2'd0, 3'd4};
      5'd5:    col_lut = {2'd1, 3'd0};
      5'd6:    col_lut = {2'd1, 3'd1};
      5'd7:    col_lut = {2'd1, 3'd2};
      5'd8:    col_lut = {2'd1, 3'd3};
      5'd9:    col_lut = {2'd1, 3'd4};
      5'd10:   col_lut = {2'd2, 3'd0};
      5'd11:   col_lut = {2'd2, 3'd1};
      5'd12:   col_lut = {2'd2, 3'd2};
      5'd13:   col_lut = {2'd2, 3'd3};
      5'd14:   col_lut = {2'd2, 3'd4};
      5'd15:   col_lut = {2'd3, 3'd0};
      5'd16:   col_lut = {2'd3, 3'd1};
      5'd17:   col_lut = {2'd3, 3'd2};
      5'd18:   col_lut = {2'd3, 3'd3};
      5'd19:   col_lut = {2'd3, 3'd4};
      default: col_lut = 5'd0;
    endcase
  endfunction

  // Entry holding register
  logic [5:0]  row_q;
  logic [1:0]  word_q;
  logic [2:0]  slot_q;
  logic [23:0] real_q;
  logic [23:0] img_q;
  logic        mode_q;
  logic        oor_q;

  // Acceptance is possible in IDLE and in the WRITE cycle; the latter keeps
  // throughput at one entry every four cycles while the write retires.
  logic       accept;
  logic       in_oor;
  logic [4:0] lut_out;

  assign accept  = chg_valid && ((state == S_IDLE) || (state == S_WRITE));
  assign in_oor  = ({1'b0, chg_row} >= ROW_LIMIT) || ({1'b0, chg_col} >= COL_LIMIT);
  assign lut_out = col_lut(chg_col[4:0]);

  // ---------------------------------------------------------------------------
  // Merge of the read word with the latched entry
  // ---------------------------------------------------------------------------
  logic [7:0]   slot_base;
  logic [47:0]  old_field;
  logic [24:0]  sum_re;
  logic [24:0]  sum_im;
  logic [23:0]  new_re;
  logic [23:0]  new_im;
  logic         sat_re;
  logic         sat_im;
  logic [255:0] merged;

  // slot * 48 as slot*32 + slot*16
  assign slot_base = {slot_q, 5'b0} + {1'b0, slot_q, 4'b0};

  always_comb begin
    old_field = mem_rd_data[slot_base +: 48];
    sum_re    = {old_field[47], old_field[47:24]} + {real_q[23], real_q};
    sum_im    = {old_field[23], old_field[23:0]}  + {img_q[23], img_q};
    new_re    = sum_re[23:0];
    new_im    = sum_im[23:0];
    sat_re    = 1'b0;
    sat_im    = 1'b0;
    if (mode_q) begin
      new_re = real_q;
      new_im = img_q;
    end else begin
      // Overflow when the extended sign disagrees with the result sign
      if (sum_re[24] != sum_re[23]) begin
        sat_re = 1'b1;
        new_re = sum_re[24] ? 24'h800000 : 24'h7FFFFF;
      end
      if (sum_im[24] != sum_im[23]) begin
        sat_im = 1'b1;
        new_im = sum_im[24] ? 24'h800000 : 24'h7FFFFF;
      end
    end
    merged = mem_rd_data;
    merged[slot_base +: 48] = {new_re, new_im};
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (chg_valid) state_nxt = S_CHECK;
      S_CHECK: state_nxt = oor_q ? S_IDLE : S_READ;
      S_READ:  state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_WRITE;
      S_WRITE: state_nxt = chg_valid ? S_CHECK : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs and datapath
  // Outputs are decoded from the next state so they line up with the state
  // they belong to while still coming straight from flops.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      chg_ready      <= 1'b1;
      mem_rd_en      <= 1'b0;
      mem_rd_addr    <= 8'd0;
      yMem_WEPin     <= 1'b0;
      yMem_WEAddress <= 8'd0;
      ydataWrite     <= 256'd0;
      upd_done       <= 1'b0;
      err_range      <= 1'b0;
      sat_flag       <= 1'b0;
      upd_count      <= 16'd0;
      row_q          <= 6'd0;
      word_q         <= 2'd0;
      slot_q         <= 3'd0;
      real_q         <= 24'd0;
      img_q          <= 24'd0;
      mode_q         <= 1'b0;
      oor_q          <= 1'b0;
    end else begin
      chg_ready  <= (state_nxt == S_IDLE) || (state_nxt == S_WRITE);
      mem_rd_en  <= (state_nxt == S_READ);
      yMem_WEPin <= (state_nxt == S_WRITE);
      upd_done   <= (state_nxt == S_WRITE);
      err_range  <= accept && in_oor;

      if (accept) begin
        row_q  <= chg_row[5:0];
        word_q <= lut_out[4:3];
        slot_q <= lut_out[2:0];
        real_q <= chg_real;
        img_q  <= chg_img;
        mode_q <= chg_mode;
        oor_q  <= in_oor;
      end

      if (state_nxt == S_READ) begin
        mem_rd_addr <= {row_q, word_q};
      end

      // ydataWrite doubles as the merge register
      if (state == S_WAIT) begin
        ydataWrite     <= merged;
        yMem_WEAddress <= {row_q, word_q};
        upd_count      <= upd_count + 16'd1;
        if (sat_re || sat_im) sat_flag <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_y_mem_update_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_y_mem_update_writer
//  Purpose  : Self-checking bench for y_mem_update_writer. A matrix-level
//             reference model predicts every memory write and range error;
//             a monitor compares DUT activity against the prediction queues.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_y_mem_update_writer;

  logic         clock;
  logic         reset;
  logic         chg_valid;
  logic         chg_ready;
  logic [15:0]  chg_row;
  logic [15:0]  chg_col;
  logic [23:0]  chg_real;
  logic [23:0]  chg_img;
  logic         chg_mode;
  logic         mem_rd_en;
  logic [7:0]   mem_rd_addr;
  logic [255:0] mem_rd_data;
  logic         yMem_WEPin;
  logic [7:0]   yMem_WEAddress;
  logic [255:0] ydataWrite;
  logic         upd_done;
  logic         err_range;
  logic         sat_flag;
  logic [15:0]  upd_count;

  y_mem_update_writer #(.MAX_ROW(64), .COLS_PER_ROW(20)) dut (
    .clock(clock), .reset(reset),
    .chg_valid(chg_valid), .chg_ready(chg_ready),
    .chg_row(chg_row), .chg_col(chg_col),
    .chg_real(chg_real), .chg_img(chg_img), .chg_mode(chg_mode),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .yMem_WEPin(yMem_WEPin), .yMem_WEAddress(yMem_WEAddress), .ydataWrite(ydataWrite),
    .upd_done(upd_done), .err_range(err_range), .sat_flag(sat_flag),
    .upd_count(upd_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Memory model: one-cycle read latency, write on enable
  // ---------------------------------------------------------------------------
  logic [255:0] mem [256];

  initial begin
    mem_rd_data = '0;
    for (int a = 0; a < 256; a++)
      for (int k = 0; k < 8; k++) mem[a][32*k +: 32] = $urandom;
    mem[3] = '1;
    mem[0][47:0] = {24'h7FFFF0, 24'h000001};
    mem[4] = '0;
    forever begin
      @(posedge clock);
      if (mem_rd_en)  mem_rd_data <= mem[mem_rd_addr];
      if (yMem_WEPin) mem[yMem_WEAddress] = ydataWrite;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: the matrix as elements, plus each word's reserved bits
  // ---------------------------------------------------------------------------
  logic [23:0] ref_re [64][20];
  logic [23:0] ref_im [64][20];
  logic [15:0] ref_res [256];
  logic [15:0] count_exp = 0;
  logic        sat_exp   = 0;

  typedef struct {
    bit           is_err;
    logic [7:0]   addr;
    logic [255:0] data;
    logic [15:0]  cnt;
    logic         sat;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] rd_q[$];

  function automatic logic [23:0] sat_add(input logic [23:0] a, input logic [23:0] b,
                                         output bit clamped);
    int s;
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    s = sa + sb;
    clamped = 0;
    if (s > 8388607)       begin s = 8388607;  clamped = 1; end
    else if (s < -8388608) begin s = -8388608; clamped = 1; end
    return 24'(s);
  endfunction

  function automatic logic [255:0] build_word(input int r, input int w);
    logic [255:0] d;
    d = '0;
    d[255:240] = ref_res[r*4 + w];
    for (int k = 0; k < 5; k++) begin
      d[48*k + 24 +: 24] = ref_re[r][w*5 + k];
      d[48*k +: 24]      = ref_im[r][w*5 + k];
    end
    return d;
  endfunction

  task automatic predict(input int r, input int c, input logic [23:0] re, input logic [23:0] im,
                         input logic m, input bit commit);
    exp_t e;
    bit cr, ci;
    int w;
    if (r >= 64 || c >= 20) begin
      e.is_err = 1; e.addr = 0; e.data = 0; e.cnt = count_exp; e.sat = sat_exp;
      exp_q.push_back(e);
      return;
    end
    w = c / 5;
    rd_q.push_back(8'(r*4 + w));
    if (!commit) return;
    if (m) begin
      ref_re[r][c] = re;
      ref_im[r][c] = im;
    end else begin
      ref_re[r][c] = sat_add(ref_re[r][c], re, cr);
      ref_im[r][c] = sat_add(ref_im[r][c], im, ci);
      if (cr || ci) sat_exp = 1;
    end
    count_exp = count_exp + 16'd1;
    e.is_err = 0; e.addr = 8'(r*4 + w); e.data = build_word(r, w);
    e.cnt = count_exp; e.sat = sat_exp;
    exp_q.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (mem_rd_en) begin
        if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
        else                  check("rd_addr", mem_rd_addr, rd_q.pop_front());
      end
      if (yMem_WEPin || upd_done) begin
        if (exp_q.size() == 0 || exp_q[0].is_err) check("wr_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("wr_done",  upd_done, yMem_WEPin);
          check("wr_addr",  yMem_WEAddress, e.addr);
          check("wr_data",  ydataWrite, e.data);
          check("wr_count", upd_count, e.cnt);
          check("wr_sat",   sat_flag, e.sat);
        end
      end
      if (err_range) begin
        if (exp_q.size() == 0 || !exp_q[0].is_err) check("err_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("err_count", upd_count, e.cnt);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  int accept_cyc = 0;

  task automatic send(input int r, input int c, input logic [23:0] re, input logic [23:0] im,
                      input logic m, input bit commit);
    int guard;
    @(negedge clock);
    chg_row = 16'(r); chg_col = 16'(c); chg_real = re; chg_img = im; chg_mode = m;
    chg_valid = 1'b1;
    guard = 0;
    while (!chg_ready && guard < 40) begin
      @(negedge clock);
      guard++;
    end
    if (!chg_ready) begin
      check("accept_timeout", 0, 1);
      chg_valid = 1'b0;
      return;
    end
    predict(r, c, re, im, m, commit);
    @(posedge clock);
    accept_cyc = cyc;
    #1;
  endtask

  task automatic drop();
    chg_valid = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clock);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [255:0] w3;
    int t0;
    int guard;

    reset = 1'b0; chg_valid = 1'b1;
    chg_row = 0; chg_col = 0; chg_real = 0; chg_img = 0; chg_mode = 0;

    // Reset held with valid asserted
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("rst_ready", chg_ready, 1);
      check("rst_rd_en", mem_rd_en, 0);
      check("rst_we",    yMem_WEPin, 0);
      check("rst_count", upd_count, 0);
      check("rst_sat",   sat_flag, 0);
    end
    check("rst_rd_addr", mem_rd_addr, 0);
    check("rst_wdata",   ydataWrite, 0);

    for (int a = 0; a < 256; a++) ref_res[a] = mem[a][255:240];
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 20; c++) begin
        ref_re[r][c] = mem[r*4 + c/5][48*(c%5) + 24 +: 24];
        ref_im[r][c] = mem[r*4 + c/5][48*(c%5) +: 24];
      end
    chg_valid = 1'b0;
    reset = 1'b1;

    // Overwrite into word 0x03 slot 1
    send(0, 16, 24'h4EBD90, 24'h5C2E27, 1'b1, 1);
    drop();
    wait_neg(2);
    check("ow_rd_en_c2",   mem_rd_en, 1);
    check("ow_rd_addr_c2", mem_rd_addr, 8'h03);
    wait_neg(2);
    check("ow_we_c4",   yMem_WEPin, 1);
    check("ow_waddr",   yMem_WEAddress, 8'h03);
    check("ow_ready_c4", chg_ready, 1);
    @(posedge clock); #1;
    w3 = '1;
    w3[95:48] = 48'h4EBD905C2E27;
    check("ow_word", mem[3], w3);
    check("ow_count", upd_count, 1);

    // Accumulate with saturation on word 0x00 slot 0
    send(0, 0, 24'h000020, 24'hFFFFFF, 1'b0, 1);
    drop();
    wait_neg(5);
    check("acc_field", mem[0][47:0], 48'h7FFFFF000000);
    check("acc_sat",   sat_flag, 1);

    // Range errors: column 20 and row 64
    send(0, 20, 24'h1, 24'h1, 1'b0, 1);
    drop();
    wait_neg(1);
    check("rng_col_err_c1", err_range, 1);
    check("rng_col_rd_c1",  mem_rd_en, 0);
    wait_neg(1);
    check("rng_col_ready_c2", chg_ready, 1);
    check("rng_col_err_c2",   err_range, 0);
    send(64, 0, 24'h1, 24'h1, 1'b0, 1);
    drop();
    wait_neg(1);
    check("rng_row_err_c1", err_range, 1);
    wait_neg(1);
    check("rng_row_ready_c2", chg_ready, 1);
    wait_neg(3);
    check("rng_count", upd_count, 2);

    // Back-to-back accumulates to the same word, valid held
    send(1, 2, 24'h000001, 24'h0, 1'b0, 1);
    t0 = accept_cyc;
    send(1, 2, 24'h000001, 24'h0, 1'b0, 1);
    check("b2b_spacing", 32'(accept_cyc - t0), 4);
    drop();
    wait_neg(5);
    check("b2b_real", mem[4][143:120], 24'd2);

    // Reset while the entry is in WAIT
    send(2, 5, 24'h123456, 24'h654321, 1'b1, 0);
    drop();
    wait_neg(3);
    reset = 1'b0;
    wait_neg(1);
    reset = 1'b1;
    count_exp = 0;
    sat_exp   = 0;
    check("mid_count", upd_count, 0);
    check("mid_sat",   sat_flag, 0);
    check("mid_ready", chg_ready, 1);
    wait_neg(3);
    send(2, 5, 24'h000100, 24'h000200, 1'b0, 1);
    drop();
    wait_neg(5);
    check("mid_next_count", upd_count, 1);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      int r, c;
      logic [23:0] re, im;
      r  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(64, 300)) : int'($urandom_range(0, 63));
      c  = $urandom_range(0, 22);
      re = 24'($urandom);
      im = 24'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        re = $urandom_range(0, 1) ? 24'h7FFF00 : 24'h8000FF;
      end
      send(r, c, re, im, 1'($urandom_range(0, 1)), 1);
      if ($urandom_range(0, 2) == 0) begin
        drop();
        wait_neg($urandom_range(1, 6));
      end
    end
    drop();

    guard = 0;
    while ((exp_q.size() != 0 || rd_q.size() != 0) && guard < 40) begin
      @(negedge clock);
      guard++;
    end
    check("drain_exp", 32'(exp_q.size()), 0);
    check("drain_rd",  32'(rd_q.size()), 0);
    check("final_count", upd_count, count_exp);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
